// File: rtl/inst_path_pkg.sv
// rtl/inst_path_pkg.sv - shared types and helpers for the instance-path decoder
package inst_path_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        EMIT
    } state_t;

    localparam int MAX_LEVELS = 8;
    localparam logic [11:0] DEFAULT_RADICES = {3'd4, 3'd4, 3'd3, 3'd2};

    // A radix of 0 would make the level meaningless, so it degenerates to 1.
    function automatic logic [2:0] radix_of(input logic [3*MAX_LEVELS-1:0] radices,
                                            input logic [2:0] lvl);
        logic [2:0] r;
        r = radices[int'(lvl)*3 +: 3];
        return (r == 3'd0) ? 3'd1 : r;
    endfunction

endpackage

// File: rtl/serial_small_div.sv
// rtl/serial_small_div.sv - restoring bit-serial divide of a W-bit value by a 3-bit divisor
module serial_small_div #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [2:0]   divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [2:0]   remainder
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  dvd;
    logic [2:0]    rem;
    logic [2:0]    dsr;
    logic [CW-1:0] cnt;
    logic          running;
    logic [3:0]    trial;
    logic [3:0]    diff;
    logic          ge;

    // The partial remainder stays below the divisor, so after subtraction it fits 3 bits.
    assign trial = {rem, dvd[W-1]};
    assign ge    = (trial >= {1'b0, dsr});
    assign diff  = trial - {1'b0, dsr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd     <= '0;
            rem     <= '0;
            dsr     <= 3'd1;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            dvd     <= dividend;
            rem     <= '0;
            dsr     <= divisor;
            cnt     <= CW'(W - 1);
            running <= 1'b1;
            done    <= 1'b0;
        end else if (running) begin
            dvd <= {dvd[W-2:0], ge};
            rem <= ge ? diff[2:0] : trial[2:0];
            if (cnt == '0) begin
                running <= 1'b0;
                done    <= 1'b1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign quotient  = dvd;
    assign remainder = rem;

endmodule

// File: rtl/inst_path_decoder.sv
// rtl/inst_path_decoder.sv - serially recovers per-level digits and root from an instance-path code
module inst_path_decoder
    import inst_path_pkg::*;
#(
    parameter int              W       = 32,
    parameter int              L       = 4,
    parameter logic [3*L-1:0]  RADICES = DEFAULT_RADICES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_code,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [2:0]   dig_level,
    output logic [2:0]   dig_value,
    output logic         dig_last,
    output logic [W-1:0] root_value,
    output logic         busy
);
    localparam logic [3*MAX_LEVELS-1:0] RADIX_TABLE = (3*MAX_LEVELS)'(RADICES);
    localparam logic [2:0]              LAST_LVL    = 3'(L - 1);

    state_t       state;
    logic [2:0]   lvl;
    logic         div_start;
    logic [W-1:0] div_dividend;
    logic [2:0]   div_lvl;
    logic [2:0]   div_divisor;
    logic         div_done;
    logic [W-1:0] div_quotient;
    logic [2:0]   div_remainder;
    logic         accept;
    logic         advance;

    assign accept  = (state == IDLE) && in_valid;
    assign advance = (state == EMIT) && dig_valid && dig_ready && !dig_last;

    // The divider is launched on the same edge that accepts a code or retires a digit,
    // which keeps each level at exactly W+1 cycles.
    assign div_start    = accept || advance;
    assign div_dividend = (state == IDLE) ? in_code : div_quotient;
    assign div_lvl      = (state == IDLE) ? 3'd0 : 3'(lvl + 3'd1);
    assign div_divisor  = radix_of(RADIX_TABLE, div_lvl);

    serial_small_div #(.W(W)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lvl        <= '0;
            in_ready   <= 1'b1;
            dig_valid  <= 1'b0;
            dig_level  <= '0;
            dig_value  <= '0;
            dig_last   <= 1'b0;
            root_value <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= DIV;
                        lvl      <= '0;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                DIV: begin
                    if (div_done) begin
                        state      <= EMIT;
                        dig_valid  <= 1'b1;
                        dig_value  <= div_remainder;
                        dig_level  <= lvl;
                        dig_last   <= (lvl == LAST_LVL);
                        root_value <= (lvl == LAST_LVL) ? div_quotient : '0;
                    end
                end
                EMIT: begin
                    if (dig_ready) begin
                        dig_valid <= 1'b0;
                        if (dig_last) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                            dig_last <= 1'b0;
                        end else begin
                            state <= DIV;
                            lvl   <= 3'(lvl + 3'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
